// File: rtl/matmul_lanes.sv
// Multi-lane matrix multiplier: M3 = M1 x M2^T, one result element per RD_LAT+K+1 cycles.
// LANES products are summed per cycle; operands are signed or unsigned per run.
module matmul_lanes #(
   parameter int A        = 16,
   parameter int B        = 32,
   parameter int C        = 24,
   parameter int BITS     = 8,
   parameter int OUT_BITS = 4*BITS,
   parameter int LANES    = 4,
   parameter int RD_LAT   = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    sgn,
   output logic                    busy,
   output logic                    done,
   output logic [$clog2(A)-1:0]    m1_addr,
   input  logic [B*BITS-1:0]       m1_data,
   output logic [$clog2(C)-1:0]    m2_addr,
   input  logic [B*BITS-1:0]       m2_data,
   output logic [$clog2(A*C)-1:0]  m3_wr_addr,
   output logic [OUT_BITS-1:0]     m3_wr_data,
   output logic                    m3_wr_ena
);

   localparam int K   = B / LANES;
   localparam int KW  = (K > 1) ? $clog2(K) : 1;
   localparam int RW  = $clog2(A);
   localparam int CW  = $clog2(C);
   localparam int AW  = $clog2(A*C);
   localparam logic [KW-1:0] K_LAST    = KW'(K-1);
   localparam logic [RW-1:0] A_LAST    = RW'(A-1);
   localparam logic [CW-1:0] C_LAST    = CW'(C-1);
   localparam logic [1:0]    WAIT_INIT = 2'((RD_LAT > 0) ? RD_LAT-1 : 0);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ACCUM, S_WRITE} state_t;

   state_t              state_q, state_d;
   logic [RW-1:0]       row_q, row_d;
   logic [CW-1:0]       col_q, col_d;
   logic [KW-1:0]       chunk_q, chunk_d;
   logic [1:0]          wait_q, wait_d;
   logic [OUT_BITS-1:0] acc_q, acc_d;
   logic                sgn_q, sgn_d;
   logic                done_q, done_d;

   logic [OUT_BITS-1:0] lane_sum;
   logic [BITS-1:0]     op1, op2;
   logic [OUT_BITS-1:0] ext1, ext2;
   int                  idx;
   state_t              next_elem;

   // Extending both operands to OUT_BITS before multiplying gives the exact product mod 2^OUT_BITS.
   always_comb begin
      lane_sum = '0;
      op1      = '0;
      op2      = '0;
      ext1     = '0;
      ext2     = '0;
      idx      = 0;
      for (int l = 0; l < LANES; l++) begin
         idx  = int'(chunk_q) * LANES + l;
         op1  = m1_data[idx*BITS +: BITS];
         op2  = m2_data[idx*BITS +: BITS];
         ext1 = {{(OUT_BITS-BITS){sgn_q & op1[BITS-1]}}, op1};
         ext2 = {{(OUT_BITS-BITS){sgn_q & op2[BITS-1]}}, op2};
         lane_sum = lane_sum + ext1 * ext2;
      end
   end

   assign next_elem = (RD_LAT == 0) ? S_ACCUM : S_FETCH;

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      chunk_d = chunk_q;
      wait_d  = wait_q;
      acc_d   = acc_q;
      sgn_d   = sgn_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               sgn_d   = sgn;
               row_d   = '0;
               col_d   = '0;
               chunk_d = '0;
               acc_d   = '0;
               wait_d  = WAIT_INIT;
               state_d = next_elem;
            end
         end
         S_FETCH: begin
            if (wait_q == 2'd0) begin
               chunk_d = '0;
               state_d = S_ACCUM;
            end else begin
               wait_d = wait_q - 2'd1;
            end
         end
         S_ACCUM: begin
            acc_d = acc_q + lane_sum;
            if (chunk_q == K_LAST) begin
               state_d = S_WRITE;
            end else begin
               chunk_d = chunk_q + 1'b1;
            end
         end
         S_WRITE: begin
            acc_d   = '0;
            chunk_d = '0;
            wait_d  = WAIT_INIT;
            state_d = next_elem;
            if (col_q == C_LAST) begin
               col_d = '0;
               if (row_q == A_LAST) begin
                  row_d   = '0;
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  row_d = row_q + 1'b1;
               end
            end else begin
               col_d = col_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         row_q   <= '0;
         col_q   <= '0;
         chunk_q <= '0;
         wait_q  <= '0;
         acc_q   <= '0;
         sgn_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         chunk_q <= chunk_d;
         wait_q  <= wait_d;
         acc_q   <= acc_d;
         sgn_q   <= sgn_d;
         done_q  <= done_d;
      end
   end

   assign busy       = (state_q != S_IDLE);
   assign done       = done_q;
   assign m1_addr    = row_q;
   assign m2_addr    = col_q;
   assign m3_wr_ena  = (state_q == S_WRITE);
   assign m3_wr_data = acc_q;
   assign m3_wr_addr = AW'(row_q) * AW'(C) + AW'(col_q);

endmodule

// File: doc/matmul_lanes.md
# matmul_lanes

Multi-lane, start-triggered matrix multiplier that computes M3 = M1 × M2ᵀ from two row-addressed source RAMs into a flat result RAM. It generalises the single-MAC engine along four axes: LANES products per cycle, a configurable source-RAM read latency, a signed or unsigned mode per run, and a start/busy/done handshake so the block can be rerun without reset. It sits between the operand RAMs and the result RAM in the accelerator datapath.

## Interface
- A, 16: rows of M1; also the number of M1 RAM words.
- B, 32: dot-product length; elements per RAM word.
- C, 24: rows of M2 (columns of M3); also the number of M2 RAM words.
- BITS, 8: operand element width.
- OUT_BITS, 4*BITS: accumulator and result width; must be ≥ 2*BITS.
- LANES, 4: parallel multipliers; must divide B. K = B/LANES.
- RD_LAT, 1: source RAM read latency in cycles, range 0..3.
- clk, input, 1: clock.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: run request, sampled in IDLE only.
- sgn, input, 1: 1 = two's-complement operands, 0 = unsigned; sampled together with start.
- busy, output, 1: high while a run is in progress.
- done, output, 1: one-cycle completion pulse.
- m1_addr, output, $clog2(A): M1 row address.
- m1_data, input, B*BITS: M1 row; element i is at [i*BITS +: BITS].
- m2_addr, output, $clog2(C): M2 row address.
- m2_data, input, B*BITS: M2 row, same packing.
- m3_wr_addr, output, $clog2(A*C): flat result address, row*C+col.
- m3_wr_data, output, OUT_BITS: result element.
- m3_wr_ena, output, 1: result write strobe.

## Operation
- States: IDLE, FETCH, ACCUM, WRITE. All outputs reset to 0; reset returns the FSM to IDLE and clears row, col, chunk, and the accumulator.
- IDLE: if start=1, latch sgn, set row=col=0, clear the accumulator, and go to FETCH. If RD_LAT=0, go straight to ACCUM. A start seen outside IDLE is ignored.
- FETCH: m1_addr=row and m2_addr=col are driven from registers and held for the whole element. The FSM waits RD_LAT cycles, then goes to ACCUM with chunk=0.
- ACCUM: for chunk k, the accumulator adds the sum over l=0..LANES-1 of m1[k*LANES+l]·m2[k*LANES+l].
  - Products are sign-extended to OUT_BITS if sgn=1, zero-extended if sgn=0.
  - All arithmetic wraps modulo 2^OUT_BITS; there is no saturation.
  - After k=K-1 the FSM goes to WRITE.
- WRITE: m3_wr_ena=1 for exactly one cycle, with m3_wr_data = the accumulator and m3_wr_addr = row*C+col.
  - The accumulator clears, and the output order advances row-major: col increments; when col=C-1, col wraps to 0 and row increments.
  - After the WRITE for row=A-1, col=C-1, the FSM goes to IDLE and done is pulsed. Otherwise it goes to FETCH (or to ACCUM if RD_LAT=0).
- busy=1 in every state except IDLE. done=1 only in the first IDLE cycle after a run.
- m3_wr_addr and m3_wr_data are don't-care when m3_wr_ena=0.

## Timing
- Per element: N = RD_LAT + K + 1 cycles.
- busy rises on the edge that samples start.
- The first write occurs in cycle RD_LAT+K+1 after that edge; subsequent writes follow every N cycles. Total: A*C writes, no gaps other than FETCH/ACCUM.
- done rises exactly A*C*N edges after the start edge, with busy falling on the same edge.
- If start=1 in the cycle done=1, a new run begins on that edge; this is a back-to-back run.
- sgn changes during a run have no effect.
- rst asserted mid-run:
  - m3_wr_ena=0 from the next cycle.
  - No done pulse.
  - A later start begins a fresh run from element (0,0).

## Test plan
- **Unsigned identity** (A=2, B=4, C=3, LANES=2, RD_LAT=1, sgn=0): M1 row0=[1,2,3,4], row1=[5,6,7,8]; M2 rows = unit vectors e0, e1, e2.
  - Writes addr 0..5 = 1,2,3,5,6,7 in that order, spaced 4 cycles apart.
  - done is observed 24 edges after start.
- **Signed mode** (B=4, LANES=4, RD_LAT=0, sgn=1): all M1 and M2 elements = 0x80 (−128) → every result = 65536.
  - Same data with sgn=0 → every result = 65536 (128²·4).
  - Elements 0xFF × 0x01 → result −4 (0xFFFFFFFC) signed, 1020 unsigned.
- **Wrap-around** (OUT_BITS=16, B=4, sgn=0): all elements 0xFF → every result = 63492 (260100 mod 65536).
- **Handshake** (any config): pulse start during busy → no effect on the write count or the done time. Hold start=1 continuously → back-to-back runs, with exactly one done pulse per run and 2×A*C writes in total.
- **Reset mid-run**: assert rst for 1 cycle after the 3rd write → no further writes, busy=0 and done=0. A subsequent start produces all A*C correct writes starting at addr 0.
- **LANES/RD_LAT sweep**: LANES∈{1,2,4}, RD_LAT∈{0,2}, random data, both sgn values → every write matches the golden model, and write spacing equals N.
